flit_packetizer: RTL and testbench

FLIT_PACKETIZER -- requirements
Module: flit_packetizer

---
 rtl/flit_packetizer.sv | 111 +++++++++++
 tb/tb_flit_packetizer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/flit_packetizer.sv
// Packet-to-flit framer: emits a head flit carrying {len,dest}, then len
// payload flits, tagging the last one as tail (or head_tail when len==0).
module flit_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_BITS  = 4,
  parameter int LEN_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pkt_valid,
  input  logic [DEST_BITS-1:0]  pkt_dest,
  input  logic [LEN_BITS-1:0]   pkt_len,
  output logic                  pkt_ready,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  input  logic                  full,
  output logic [DATA_WIDTH+1:0] write_data,
  output logic                  wrtEn,
  output logic                  pkt_done
);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    PAYLOAD
  } state_t;

  state_t                state, state_nxt;
  logic [DEST_BITS-1:0]  dest_q;
  logic [LEN_BITS-1:0]   len_q;
  logic [LEN_BITS-1:0]   rem_q, rem_nxt;
  logic [DATA_WIDTH-1:0] header;

  assign header = DATA_WIDTH'({len_q, dest_q});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dest_q <= '0;
      len_q  <= '0;
      rem_q  <= '0;
    end else begin
      state <= state_nxt;
      rem_q <= rem_nxt;
      if (state == IDLE && pkt_valid) begin
        dest_q <= pkt_dest;
        len_q  <= pkt_len;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem_q;
    pkt_ready  = 1'b0;
    word_ready = 1'b0;
    wrtEn      = 1'b0;
    pkt_done   = 1'b0;
    write_data = '0;
    unique case (state)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) state_nxt = HEAD;
      end
      HEAD: begin
        wrtEn = ~full;
        if (!full) begin
          if (len_q == '0) begin
            write_data = {T_HT, header};
            pkt_done   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            write_data = {T_HEAD, header};
            rem_nxt    = len_q;
            state_nxt  = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        word_ready = ~full;
        if (word_valid && !full) begin
          wrtEn   = 1'b1;
          rem_nxt = rem_q - LEN_BITS'(1);
          if (rem_q == LEN_BITS'(1)) begin
            write_data = {T_TAIL, word_data};
            pkt_done   = 1'b1;
            state_nxt  = IDLE;
          end else begin
            write_data = {T_BODY, word_data};
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // state is already IDLE under reset; this also silences pkt_ready
    if (reset) begin
      pkt_ready  = 1'b0;
      word_ready = 1'b0;
      wrtEn      = 1'b0;
      pkt_done   = 1'b0;
      write_data = '0;
    end
  end

endmodule

// File: tb/tb_flit_packetizer.sv
// Randomized bench for flit_packetizer against a flit-queue reference model.
module tb_flit_packetizer;

  localparam int DW = 32;
  localparam int DB = 4;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          pkt_valid;
  logic [DB-1:0] pkt_dest;
  logic [LB-1:0] pkt_len;
  logic          pkt_ready;
  logic [DW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          full;
  logic [DW+1:0] write_data;
  logic          wrtEn;
  logic          pkt_done;

  flit_packetizer #(
    .DATA_WIDTH(DW),
    .DEST_BITS (DB),
    .LEN_BITS  (LB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_dest  (pkt_dest),
    .pkt_len   (pkt_len),
    .pkt_ready (pkt_ready),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .full      (full),
    .write_data(write_data),
    .wrtEn     (wrtEn),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW+1:0]    exp_q[$];
  logic [DW-1:0]    word_q[$];
  logic [DB+LB-1:0] pkt_q[$];

  int full_pct  = 0;
  int wv_pct    = 100;
  int pv_pct    = 100;
  int cyc       = 0;
  int last_done = -1;
  bit chk_gap   = 0;

  task automatic push_pkt(input int l, input int d);
    logic [LB-1:0] lv;
    logic [DB-1:0] dv;
    lv = LB'(l);
    dv = DB'(d);
    pkt_q.push_back({lv, dv});
  endtask

  task automatic accept(input logic [LB-1:0] l, input logic [DB-1:0] d);
    logic [DW+1:0] e;
    logic [DW-1:0] w;
    e = '0;
    e[DW+1:DW] = (l == 0) ? 2'b11 : 2'b01;
    e[DB+LB-1:0] = {l, d};
    exp_q.push_back(e);
    for (int i = 0; i < int'(l); i++) begin
      w = $urandom;
      word_q.push_back(w);
      exp_q.push_back({(i == int'(l) - 1) ? 2'b10 : 2'b00, w});
    end
  endtask

  task automatic cycle();
    bit idle, head_next, exp_we, exp_wr;
    @(negedge clk);
    cyc++;
    idle      = (exp_q.size() == 0);
    head_next = !idle && exp_q[0][DW];
    exp_wr    = !idle && !head_next && !full;
    exp_we    = !idle && !full && (head_next || word_valid);
    check("pkt_ready", 64'(pkt_ready), 64'(idle));
    check("word_ready", 64'(word_ready), 64'(exp_wr));
    check("wrtEn", 64'(wrtEn), 64'(exp_we));
    check("pkt_done", 64'(pkt_done), 64'(exp_we && exp_q.size() == 1));
    if (exp_we) begin
      check("flit", 64'(write_data), 64'(exp_q[0]));
      if (head_next && chk_gap && last_done >= 0)
        check("b2b_gap", 64'(cyc - last_done), 64'd2);
      if (exp_q.size() == 1) last_done = cyc;
      void'(exp_q.pop_front());
    end else begin
      check("idle_data", 64'(write_data), 64'd0);
    end
    if (exp_wr && word_valid) void'(word_q.pop_front());
    if (idle && pkt_valid) begin
      accept(pkt_len, pkt_dest);
      if (pkt_q.size() > 0) void'(pkt_q.pop_front());
    end
    @(posedge clk);
    #1;
    pkt_valid = (pkt_q.size() > 0) && ($urandom_range(99) < pv_pct);
    if (pkt_q.size() > 0) {pkt_len, pkt_dest} = pkt_q[0];
    else {pkt_len, pkt_dest} = (DB + LB)'($urandom);
    full       = ($urandom_range(99) < full_pct);
    word_valid = (word_q.size() > 0) && ($urandom_range(99) < wv_pct);
    word_data  = (word_q.size() > 0) ? word_q[0] : $urandom;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((pkt_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_pkt_ready"}, 64'(pkt_ready), 64'd0);
    check({tag, "_word_ready"}, 64'(word_ready), 64'd0);
    check({tag, "_wrtEn"}, 64'(wrtEn), 64'd0);
    check({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
    check({tag, "_data"}, 64'(write_data), 64'd0);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    pkt_valid  = 1'b0;
    pkt_dest   = '0;
    pkt_len    = '0;
    word_data  = '0;
    word_valid = 1'b0;
    full       = 1'b0;
    #2;
    check_reset_outs("init");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    push_pkt(2, 3);
    run_idle(50);

    push_pkt(0, 5);
    run_idle(50);

    full_pct = 100;
    push_pkt(1, 9);
    repeat (5) cycle();
    full_pct = 0;
    run_idle(50);

    wv_pct = 50;
    push_pkt(2, 7);
    run_idle(100);
    wv_pct = 100;

    chk_gap   = 1;
    last_done = -1;
    push_pkt(1, 1);
    push_pkt(1, 2);
    push_pkt(0, 4);
    run_idle(50);
    chk_gap = 0;

    push_pkt(4, 6);
    n = 0;
    while (exp_q.size() != 3 && n < 50) begin
      cycle();
      n++;
    end
    check("rst_setup_timeout", 64'(n >= 50), 64'd0);
    #2 reset = 1'b1;
    #1;
    check_reset_outs("async");
    exp_q.delete();
    word_q.delete();
    pkt_valid  = 1'b0;
    word_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    push_pkt(3, 10);
    run_idle(50);

    push_pkt(15, 15);
    run_idle(200);

    for (int p = 0; p < 60; p++) begin
      full_pct = $urandom_range(40);
      wv_pct   = 40 + $urandom_range(60);
      pv_pct   = 30 + $urandom_range(70);
      if (p % 10 == 0) push_pkt(15, $urandom_range(15));
      else push_pkt($urandom_range(15), $urandom_range(15));
      if (p % 3 == 0) push_pkt($urandom_range(2), $urandom_range(15));
      run_idle(2000);
    end
    full_pct = 0;
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
